dram_port_arbiter: RTL and testbench
====================================

# dram_port_arbiter

Memory-side responder for the per-hart DRAM request ports that each CPU/MMU wrapper drives: `w_dram_addr`, `w_dram_wdata`, `w_dram_we_t`, `w_dram_le`, `w_dram_ctrl`, with `w_dram_busy` and `w_dram_odata` returned. It captures one-cycle request strobes from `NHARTS` harts and arbitrates them round-robin onto a single downstream DRAM controller port. It returns per-hart busy and read data, and publishes the granted hart on `w_grant`. It sits between the hart array and the DRAM controller in the SoC top.

## Interface
Parameters:
- `NHARTS`, 2, number of requesting harts (2..8).

Ports (packed buses, hart i occupies slice i):
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `w_dram_addr`  in  32*NHARTS  per-hart byte address, valid in strobe cycle.
- `w_dram_wdata`  in  32*NHARTS  per-hart write data, valid in strobe cycle.
- `w_dram_we_t`  in  NHARTS  per-hart write strobe, 1-cycle pulse.
- `w_dram_le`  in  NHARTS  per-hart read strobe, 1-cycle pulse.
- `w_dram_ctrl`  in  3*NHARTS  per-hart access control; passed through unchanged.
- `w_dram_busy`  out  NHARTS  per-hart busy.
- `w_dram_odata`  out  32*NHARTS  per-hart read data register.
- `w_grant`  out  32  hart id currently owning the downstream port; 0 when idle.
- `w_proto_err`  out  1  sticky protocol-violation flag.
- `m_addr`, `m_wdata`  out  32 each  downstream address/data.
- `m_ctrl`  out  3  downstream control.
- `m_we`, `m_le`  out  1 each  downstream strobes, 1-cycle pulse.
- `m_busy`  in  1  downstream busy.
- `m_odata`  in  32  downstream read data, valid when `m_busy`=0 after an access.

## Operation
- Per-hart capture: a strobe (`we_t` or `le`) with `busy[i]`=0 latches addr, wdata, ctrl, and the we flag into pending slot i, and sets `pend[i]`.
- `busy[i]` = `pend[i]`, registered. It goes high the cycle after the strobe and stays high until completion.
- Protocol violations set `w_proto_err` (sticky until reset); the offending strobe is ignored:
  - strobe while `busy[i]`=1;
  - `we_t` and `le` high together on one hart.
- State machine `IDLE`, `ISSUE`, `WAIT`:
  - **IDLE**: if any `pend` set, select a winner round-robin, starting at hart `(last+1) mod NHARTS`. Load the winner's slot onto the `m_*` registers and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE**: `m_we` or `m_le` high for exactly this cycle; `m_addr`, `m_wdata`, `m_ctrl` held. Go to WAIT.
  - **WAIT**: ignore `m_busy` in the first WAIT cycle (downstream may raise it late). From the second WAIT cycle, sample `m_busy`=0 to complete:
    - if a read, capture `m_odata` into `w_dram_odata[winner]`; on a write, `odata` keeps its old value;
    - clear `pend[winner]`;
    - set `last`=winner;
    - return to IDLE.
- `w_grant` = winner id during ISSUE and WAIT; 0 in IDLE.
- Hart 0 is reported as 0 in both cases; `w_grant` is qualified by state.
- `m_addr`, `m_wdata`, `m_ctrl` hold their last values in IDLE; the strobes stay 0.
- Requests arriving during another hart's access are captured and wait; no request is ever dropped.
- A hart's slot cannot change while pending.

## Timing
- Reset values: all `busy`=0, all `odata`=0, `w_grant`=0, `w_proto_err`=0, `m_we`=`m_le`=0, `m_addr`=`m_wdata`=0, `m_ctrl`=0, state=IDLE, `last`=NHARTS-1 (so hart 0 wins first).
- Single request, idle arbiter, strobe in cycle T:
  - `busy` high from T+1;
  - downstream strobe in T+2;
  - WAIT from T+3.
- Completion: if `m_busy` is first sampled 0 in cycle W (W ≥ T+4), then `busy` falls and `odata` is valid from W+1.
- Zero-wait memory: strobe in T gives `busy` low in T+5, so `busy` lasts 4 cycles.
- Back-to-back: a completion in W returns to IDLE at W+1; the next pending hart's ISSUE is at W+2.
- A hart may strobe again in the first cycle it sees `busy`=0.
- Simultaneous strobes from all harts in one cycle: served in round-robin order, one full access each, no gap beyond the IDLE cycle.
- Reset mid-access: reset is asynchronous. All pending slots clear, strobes drop immediately, and the in-flight downstream access is abandoned.

## Test plan
- Reset, then hart 0 reads 0x8000_0100, memory returns 0xDEAD_BEEF after `m_busy` is high for 3 cycles -> one `m_le` pulse with `m_addr`=0x8000_0100; `busy[0]` high until completion; then `odata[0]`=0xDEAD_BEEF; `w_grant`=0 afterwards.
- Hart 0 and hart 1 write in the same cycle, 0x10 and 0x20, with `last`=reset -> hart 0 is served first (`w_grant`=0), then hart 1 (`w_grant`=1). `m_wdata` matches each; `odata` is unchanged.
- Continuous requests from both harts for 8 accesses -> strict alternation 0,1,0,1...; each `busy` falls exactly once per access.
- Zero-wait memory (`m_busy` always 0), single read -> `busy` high for exactly 4 cycles, per the latency above.
- Hart 1 strobes again while `busy[1]`=1, and in another run drives `we_t`+`le` together -> `w_proto_err`=1 sticky; no extra downstream access; the original access completes normally.
- Assert `RST` during WAIT -> `m_le` and `m_we` are 0 immediately; after release all outputs are at reset values and a new request is served normally.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter between per-hart DRAM strobe ports and one downstream controller port.
// Each hart owns a single pending slot; busy is the registered pending flag.
module dram_port_arbiter #(
  parameter int NHARTS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [32*NHARTS-1:0]   w_dram_addr,
  input  logic [32*NHARTS-1:0]   w_dram_wdata,
  input  logic [NHARTS-1:0]      w_dram_we_t,
  input  logic [NHARTS-1:0]      w_dram_le,
  input  logic [3*NHARTS-1:0]    w_dram_ctrl,
  output logic [NHARTS-1:0]      w_dram_busy,
  output logic [32*NHARTS-1:0]   w_dram_odata,
  output logic [31:0]            w_grant,
  output logic                   w_proto_err,
  output logic [31:0]            m_addr,
  output logic [31:0]            m_wdata,
  output logic [2:0]             m_ctrl,
  output logic                   m_we,
  output logic                   m_le,
  input  logic                   m_busy,
  input  logic [31:0]            m_odata
);

  localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [31:0] addr_in  [NHARTS];
  logic [31:0] wdata_in [NHARTS];
  logic [2:0]  ctrl_in  [NHARTS];

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     last_q, last_d;
  logic              first_wait_q, first_wait_d;
  logic [NHARTS-1:0] pend_q, pend_d;
  logic [NHARTS-1:0] slot_we_q, slot_we_d;
  logic [31:0]       slot_addr_q  [NHARTS];
  logic [31:0]       slot_addr_d  [NHARTS];
  logic [31:0]       slot_wdata_q [NHARTS];
  logic [31:0]       slot_wdata_d [NHARTS];
  logic [2:0]        slot_ctrl_q  [NHARTS];
  logic [2:0]        slot_ctrl_d  [NHARTS];
  logic [31:0]       odata_q [NHARTS];
  logic [31:0]       odata_d [NHARTS];
  logic              proto_err_q, proto_err_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [2:0]        m_ctrl_q, m_ctrl_d;
  logic              m_we_q, m_we_d;
  logic              m_le_q, m_le_d;

  logic              found;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     hi;

  genvar g;
  generate
    for (g = 0; g < NHARTS; g++) begin : g_hart
      assign addr_in[g]                = w_dram_addr[32*g +: 32];
      assign wdata_in[g]               = w_dram_wdata[32*g +: 32];
      assign ctrl_in[g]                = w_dram_ctrl[3*g +: 3];
      assign w_dram_odata[32*g +: 32]  = odata_q[g];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_d       = last_q;
    first_wait_d = first_wait_q;
    pend_d       = pend_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_ctrl_d  = slot_ctrl_q;
    odata_d      = odata_q;
    proto_err_d  = proto_err_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_ctrl_d     = m_ctrl_q;
    m_we_d       = m_we_q;
    m_le_d       = m_le_q;
    found        = 1'b0;
    cand         = '0;
    hi           = '0;

    // A strobe is only accepted into an empty slot; anything else is flagged and dropped.
    for (int unsigned i = 0; i < NHARTS; i++) begin
      hi = IW'(i);
      if (w_dram_we_t[hi] || w_dram_le[hi]) begin
        if ((w_dram_we_t[hi] && w_dram_le[hi]) || pend_q[hi]) begin
          proto_err_d = 1'b1;
        end else begin
          pend_d[hi]       = 1'b1;
          slot_we_d[hi]    = w_dram_we_t[hi];
          slot_addr_d[hi]  = addr_in[hi];
          slot_wdata_d[hi] = wdata_in[hi];
          slot_ctrl_d[hi]  = ctrl_in[hi];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          for (int unsigned k = 1; k <= NHARTS; k++) begin
            cand = IW'((32'(last_q) + k) % NHARTS);
            if (!found && pend_q[cand]) begin
              found = 1'b1;
              win_d = cand;
            end
          end
          m_addr_d  = slot_addr_q[win_d];
          m_wdata_d = slot_wdata_q[win_d];
          m_ctrl_d  = slot_ctrl_q[win_d];
          m_we_d    = slot_we_q[win_d];
          m_le_d    = !slot_we_q[win_d];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_we_d       = 1'b0;
        m_le_d       = 1'b0;
        first_wait_d = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // Downstream may raise busy late, so the first WAIT cycle never completes.
        first_wait_d = 1'b0;
        if (!first_wait_q && !m_busy) begin
          if (!slot_we_q[win_q]) begin
            odata_d[win_q] = m_odata;
          end
          pend_d[win_q] = 1'b0;
          last_d        = win_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      win_q        <= '0;
      last_q       <= IW'(NHARTS - 1);
      first_wait_q <= 1'b0;
      pend_q       <= '0;
      slot_we_q    <= '0;
      slot_addr_q  <= '{default: '0};
      slot_wdata_q <= '{default: '0};
      slot_ctrl_q  <= '{default: '0};
      odata_q      <= '{default: '0};
      proto_err_q  <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_ctrl_q     <= '0;
      m_we_q       <= 1'b0;
      m_le_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_q       <= last_d;
      first_wait_q <= first_wait_d;
      pend_q       <= pend_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_ctrl_q  <= slot_ctrl_d;
      odata_q      <= odata_d;
      proto_err_q  <= proto_err_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_ctrl_q     <= m_ctrl_d;
      m_we_q       <= m_we_d;
      m_le_q       <= m_le_d;
    end
  end

  assign w_dram_busy = pend_q;
  assign w_grant     = (state_q == S_IDLE) ? '0 : 32'(win_q);
  assign w_proto_err = proto_err_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_ctrl      = m_ctrl_q;
  assign m_we        = m_we_q;
  assign m_le        = m_le_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: expected downstream accesses and per-hart
// completions are queued by the stimulus and popped by an independent monitor.
module tb_dram_port_arbiter;

  localparam int N = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [32*N-1:0]   w_dram_addr;
  logic [32*N-1:0]   w_dram_wdata;
  logic [N-1:0]      w_dram_we_t;
  logic [N-1:0]      w_dram_le;
  logic [3*N-1:0]    w_dram_ctrl;
  logic [N-1:0]      w_dram_busy;
  logic [32*N-1:0]   w_dram_odata;
  logic [31:0]       w_grant;
  logic              w_proto_err;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [2:0]        m_ctrl;
  logic              m_we;
  logic              m_le;
  logic              m_busy;
  logic [31:0]       m_odata;

  dram_port_arbiter #(.NHARTS(N)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_le    (w_dram_le),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_busy  (w_dram_busy),
    .w_dram_odata (w_dram_odata),
    .w_grant      (w_grant),
    .w_proto_err  (w_proto_err),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_ctrl       (m_ctrl),
    .m_we         (m_we),
    .m_le         (m_le),
    .m_busy       (m_busy),
    .m_odata      (m_odata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          hart;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
  } acc_t;

  typedef struct {
    int          hart;
    logic [31:0] odata;
  } cmp_t;

  acc_t        acc_q[$];
  cmp_t        cmp_q[$];
  logic [31:0] odata_model [N];
  int          checks   = 0;
  int          failures = 0;
  int          lat;
  int          rem;
  logic [31:0] mem_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Downstream memory: busy for `lat` negedges after a strobe, data valid when busy drops.
  initial begin
    m_busy  = 1'b0;
    m_odata = 32'h0BAD_0BAD;
    rem     = 0;
    mem_rd  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_busy = 1'b0;
        rem    = 0;
      end else if (m_le || m_we) begin
        mem_rd = mem_word(m_addr);
        if (lat == 0) begin
          m_busy  = 1'b0;
          m_odata = mem_rd;
        end else begin
          m_busy  = 1'b1;
          m_odata = 32'h0BAD_0BAD;
          rem     = lat;
        end
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_busy  = 1'b0;
          m_odata = mem_rd;
        end
      end
    end
  end

  // Monitor: downstream strobes and busy falling edges are matched against the queues.
  initial begin
    logic [N-1:0] prev_busy;
    acc_t e;
    cmp_t c;
    prev_busy = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_busy = '0;
      end else begin
        if (m_le || m_we) begin
          if (acc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access actual=addr 0x%08h we=%0b le=%0b required=no access", m_addr, m_we, m_le);
          end else begin
            e = acc_q.pop_front();
            chk("acc_grant", w_grant, 32'(e.hart));
            chk("acc_strobes", {30'd0, m_we, m_le}, e.we ? 32'd2 : 32'd1);
            chk("acc_addr", m_addr, e.addr);
            if (e.we) chk("acc_wdata", m_wdata, e.wdata);
            chk("acc_ctrl", 32'(m_ctrl), 32'(e.ctrl));
          end
        end
        for (int h = 0; h < N; h++) begin
          if (prev_busy[h] && !w_dram_busy[h]) begin
            if (cmp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_completion actual=hart %0d required=none", h);
            end else begin
              c = cmp_q.pop_front();
              chk("cmp_hart", 32'(h), 32'(c.hart));
              chk("cmp_odata", w_dram_odata[32*h +: 32], c.odata);
            end
          end
        end
        prev_busy = w_dram_busy;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    w_dram_we_t = '0;
    w_dram_le   = '0;
  endtask

  task automatic strobe(input int h, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c);
    w_dram_addr[32*h +: 32]  = a;
    w_dram_wdata[32*h +: 32] = d;
    w_dram_ctrl[3*h +: 3]    = c;
    if (we) w_dram_we_t[h] = 1'b1;
    else    w_dram_le[h]   = 1'b1;
  endtask

  task automatic expect_acc(input int h, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] c);
    acc_t e;
    cmp_t k;
    e.hart = h; e.we = we; e.addr = a; e.wdata = d; e.ctrl = c;
    acc_q.push_back(e);
    if (!we) odata_model[h] = mem_word(a);
    k.hart = h; k.odata = odata_model[h];
    cmp_q.push_back(k);
  endtask

  task automatic req(input int h, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] c);
    strobe(h, we, a, d, c);
    expect_acc(h, we, a, d, c);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while ((acc_q.size() != 0 || cmp_q.size() != 0 || w_dram_busy != '0) && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s_timeout actual=pending acc=%0d cmp=%0d required=drained within %0d cycles",
               name, acc_q.size(), cmp_q.size(), max);
    end
  endtask

  task automatic check_rst(input string p);
    chk({p, "_busy"}, 32'(w_dram_busy), 32'd0);
    chk({p, "_odata0"}, w_dram_odata[31:0], 32'd0);
    chk({p, "_odata1"}, w_dram_odata[63:32], 32'd0);
    chk({p, "_grant"}, w_grant, 32'd0);
    chk({p, "_proto_err"}, 32'(w_proto_err), 32'd0);
    chk({p, "_strobes"}, {30'd0, m_we, m_le}, 32'd0);
    chk({p, "_m_addr"}, m_addr, 32'd0);
    chk({p, "_m_wdata"}, m_wdata, 32'd0);
    chk({p, "_m_ctrl"}, 32'(m_ctrl), 32'd0);
  endtask

  task automatic do_reset(input string p);
    RST         = 1'b1;
    w_dram_we_t = '0;
    w_dram_le   = '0;
    acc_q.delete();
    cmp_q.delete();
    odata_model = '{default: '0};
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_rst(p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt [N];
    RST          = 1'b1;
    w_dram_addr  = '0;
    w_dram_wdata = '0;
    w_dram_we_t  = '0;
    w_dram_le    = '0;
    w_dram_ctrl  = '0;
    lat          = 0;
    do_reset("rst0");

    // Single read from hart 0, memory busy for 3 cycles.
    lat = 3;
    tick();
    req(0, 1'b0, 32'h8000_0100, 32'h0, 3'b101);
    tick();
    chk("t1_busy_next_cycle", 32'(w_dram_busy), 32'd1);
    wait_idle("t1", 40);
    chk("t1_odata0", w_dram_odata[31:0], 32'hDEAD_BEEF);
    chk("t1_grant_after", w_grant, 32'd0);

    // Simultaneous writes after reset: hart 0 first, then hart 1; odata untouched.
    do_reset("rst1");
    lat = 1;
    req(0, 1'b1, 32'h0000_0010, 32'h1111_0000, 3'd2);
    req(1, 1'b1, 32'h0000_0020, 32'h2222_0000, 3'd3);
    wait_idle("t2", 40);
    chk("t2_odata0", w_dram_odata[31:0], 32'd0);
    chk("t2_odata1", w_dram_odata[63:32], 32'd0);

    // Continuous traffic from both harts: strict alternation starting with hart 0.
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) expect_acc(0, 1'b1, 32'h1000 + 32'(4 * (k / 2)), 32'hA000_0000 + 32'(k / 2), 3'd1);
      else            expect_acc(1, 1'b0, 32'h2000 + 32'(4 * (k / 2)), 32'h0, 3'd6);
    end
    cnt = '{default: 0};
    n = 0;
    while ((cnt[0] < 4 || cnt[1] < 4) && n < 200) begin
      if (cnt[0] < 4 && !w_dram_busy[0]) begin
        strobe(0, 1'b1, 32'h1000 + 32'(4 * cnt[0]), 32'hA000_0000 + 32'(cnt[0]), 3'd1);
        cnt[0]++;
      end
      if (cnt[1] < 4 && !w_dram_busy[1]) begin
        strobe(1, 1'b0, 32'h2000 + 32'(4 * cnt[1]), 32'h0, 3'd6);
        cnt[1]++;
      end
      tick();
      n++;
    end
    wait_idle("t3", 100);
    chk("t3_odata1_last", w_dram_odata[63:32], mem_word(32'h200C));

    // Zero-wait memory: busy lasts exactly 4 cycles.
    lat = 0;
    req(1, 1'b0, 32'h0000_3000, 32'h0, 3'd0);
    tick();
    n = 0;
    while (w_dram_busy[1] && n < 20) begin
      n++;
      tick();
    end
    chk("t4_busy_cycles", 32'(n), 32'd4);
    wait_idle("t4", 20);

    // Re-strobe while busy: flagged, ignored, original access completes.
    lat = 2;
    req(1, 1'b0, 32'h0000_4000, 32'h0, 3'd4);
    tick();
    strobe(1, 1'b1, 32'h0000_5000, 32'h5555_5555, 3'd7);
    tick();
    chk("t5_proto_err_set", 32'(w_proto_err), 32'd1);
    wait_idle("t5", 40);
    chk("t5_proto_err_sticky", 32'(w_proto_err), 32'd1);
    chk("t5_odata1", w_dram_odata[63:32], mem_word(32'h4000));

    // we_t and le together on hart 1 alongside a legal read on hart 0.
    do_reset("rst2");
    req(0, 1'b0, 32'h0000_6000, 32'h0, 3'd2);
    w_dram_we_t[1] = 1'b1;
    w_dram_le[1]   = 1'b1;
    tick();
    chk("t6_proto_err", 32'(w_proto_err), 32'd1);
    chk("t6_busy", 32'(w_dram_busy), 32'd1);
    wait_idle("t6", 40);
    chk("t6_odata0", w_dram_odata[31:0], mem_word(32'h6000));

    // Reset asserted asynchronously during WAIT, then a fresh request.
    do_reset("rst3");
    lat = 5;
    req(0, 1'b0, 32'h0000_7000, 32'h0, 3'd1);
    repeat (3) tick();
    #2;
    RST = 1'b1;
    #1;
    chk("t7_async_strobes", {30'd0, m_we, m_le}, 32'd0);
    chk("t7_async_busy", 32'(w_dram_busy), 32'd0);
    chk("t7_async_grant", w_grant, 32'd0);
    do_reset("rst4");
    lat = 1;
    tick();
    req(1, 1'b1, 32'h0000_8000, 32'h8888_0001, 3'd5);
    wait_idle("t7", 40);
    chk("t7_odata1", w_dram_odata[63:32], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
